// File: rtl/ov7670_capture.sv
// OV7670 YUV422 capture: keeps the luminance bytes and writes 4-bit gray pixels
// into the frame buffer, with a linear address and frame/line sanity flags.
module ov7670_capture #(
  parameter int unsigned H_PIXELS     = 640,
  parameter int unsigned V_LINES      = 480,
  parameter int unsigned Y_FIRST      = 1,
  parameter logic        VSYNC_ACTIVE = 1'b1
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        capture_en,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic        frame_we,
  output logic [18:0] frame_addr,
  output logic [3:0]  frame_pixel,
  output logic        frame_done,
  output logic        line_err,
  output logic        overflow,
  output logic [7:0]  frame_cnt
);

  localparam logic [18:0] LAST_ADDR = 19'(H_PIXELS * V_LINES - 1);
  localparam logic [15:0] H_CNT     = 16'(H_PIXELS);
  localparam logic [15:0] V_CNT     = 16'(V_LINES);
  localparam logic        Y_PHASE   = (Y_FIRST != 0) ? 1'b0 : 1'b1;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    VBLANK    = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic        vsync_r, vsync_rr, href_r, href_rr;
  logic [7:0]  data_r;
  logic        phase;
  logic [15:0] pix_cnt, line_cnt;
  logic [18:0] addr_cnt;
  logic        addr_full;

  logic        vs_blank, vs_blank_d, vs_rise, vs_fall, href_fall;
  logic        in_active, y_byte, line_end, frame_end, frame_start;
  logic [15:0] pix_line, lines_total;
  logic        unused_low;

  assign unused_low = ^data_r[3:0];

  assign vs_blank    = (vsync_r == VSYNC_ACTIVE);
  assign vs_blank_d  = (vsync_rr == VSYNC_ACTIVE);
  assign vs_rise     = vs_blank & ~vs_blank_d;
  assign vs_fall     = ~vs_blank & vs_blank_d;
  assign href_fall   = href_rr & ~href_r;

  assign in_active   = (state == ACTIVE);
  assign y_byte      = in_active && href_r && (phase == Y_PHASE);
  assign frame_start = (state == VBLANK) && vs_fall && capture_en;
  assign frame_end   = in_active && vs_rise;
  // A line still open when vsync arrives is closed and checked in the same cycle.
  assign line_end    = in_active && (href_fall || (vs_rise && href_r));
  assign pix_line    = pix_cnt + {15'd0, y_byte};
  assign lines_total = line_cnt + {15'd0, line_end};

  always_ff @(posedge pclk) begin
    if (rst) begin
      vsync_r  <= ~VSYNC_ACTIVE;
      vsync_rr <= ~VSYNC_ACTIVE;
      href_r   <= 1'b0;
      href_rr  <= 1'b0;
      data_r   <= '0;
    end else begin
      vsync_r  <= cam_vsync;
      vsync_rr <= vsync_r;
      href_r   <= cam_href;
      href_rr  <= href_r;
      data_r   <= cam_data;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) state <= SYNC_WAIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SYNC_WAIT: if (vs_rise)     state_nxt = VBLANK;
      VBLANK:    if (frame_start) state_nxt = ACTIVE;
      ACTIVE:    if (vs_rise)     state_nxt = VBLANK;
      default:                    state_nxt = SYNC_WAIT;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      frame_we    <= 1'b0;
      frame_addr  <= '0;
      frame_pixel <= '0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
      overflow    <= 1'b0;
      frame_cnt   <= '0;
      phase       <= 1'b0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      addr_cnt    <= '0;
      addr_full   <= 1'b0;
    end else begin
      frame_we   <= 1'b0;
      frame_done <= 1'b0;
      if (frame_start) begin
        frame_addr <= '0;
        addr_cnt   <= '0;
        addr_full  <= 1'b0;
        phase      <= 1'b0;
        pix_cnt    <= '0;
        line_cnt   <= '0;
        line_err   <= 1'b0;
        overflow   <= 1'b0;
      end else if (in_active) begin
        // addr_cnt is the next free slot; frame_addr shows the slot being written.
        if (y_byte) begin
          if (addr_full) begin
            overflow <= 1'b1;
          end else begin
            frame_we    <= 1'b1;
            frame_pixel <= data_r[7:4];
            frame_addr  <= addr_cnt;
            if (addr_cnt == LAST_ADDR) addr_full <= 1'b1;
            else                       addr_cnt  <= addr_cnt + 19'd1;
          end
        end
        phase <= href_r ? ~phase : 1'b0;
        if (line_end) begin
          pix_cnt  <= '0;
          line_cnt <= lines_total;
        end else if (y_byte) begin
          pix_cnt <= pix_line;
        end
        if ((line_end && (pix_line != H_CNT)) || (frame_end && (lines_total != V_CNT)))
          line_err <= 1'b1;
        if (frame_end) begin
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture: 4x4 frames on two instances (Y_FIRST=1 and 0)
// sharing one camera bus; writes are logged and compared against expected tables.
module tb_ov7670_capture;

  localparam int H = 4;
  localparam int V = 4;

  logic        pclk = 1'b0;
  logic        rst, capture_en, cam_vsync, cam_href;
  logic [7:0]  cam_data;

  logic        we1, done1, lerr1, ovf1;
  logic [18:0] addr1;
  logic [3:0]  pix1;
  logic [7:0]  fcnt1;
  logic        we0, done0, lerr0, ovf0;
  logic [18:0] addr0;
  logic [3:0]  pix0;
  logic [7:0]  fcnt0;

  ov7670_capture #(.H_PIXELS(H), .V_LINES(V), .Y_FIRST(1), .VSYNC_ACTIVE(1'b1)) dut (
    .pclk(pclk), .rst(rst), .capture_en(capture_en), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .frame_we(we1), .frame_addr(addr1),
    .frame_pixel(pix1), .frame_done(done1), .line_err(lerr1), .overflow(ovf1),
    .frame_cnt(fcnt1)
  );

  ov7670_capture #(.H_PIXELS(H), .V_LINES(V), .Y_FIRST(0), .VSYNC_ACTIVE(1'b1)) dut0 (
    .pclk(pclk), .rst(rst), .capture_en(capture_en), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .frame_we(we0), .frame_addr(addr0),
    .frame_pixel(pix0), .frame_done(done0), .line_err(lerr0), .overflow(ovf0),
    .frame_cnt(fcnt0)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int w1_addr[$], w1_pix[$], w1_cyc[$];
  int w0_addr[$], w0_pix[$], w0_cyc[$];
  int e1_pix[$], e1_cyc[$], e0_pix[$], e0_cyc[$];
  int nd1, nd0;
  int k;
  int checks = 0;
  int failures = 0;

  always @(posedge pclk) begin
    #1;
    if (we1 === 1'b1) begin
      w1_addr.push_back(int'(addr1)); w1_pix.push_back(int'(pix1)); w1_cyc.push_back(cyc);
    end
    if (we0 === 1'b1) begin
      w0_addr.push_back(int'(addr0)); w0_pix.push_back(int'(pix0)); w0_cyc.push_back(cyc);
    end
    if (done1 === 1'b1) nd1++;
    if (done0 === 1'b1) nd0++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_writes();
    w1_addr.delete(); w1_pix.delete(); w1_cyc.delete();
    w0_addr.delete(); w0_pix.delete(); w0_cyc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge pclk);
      cam_href = 1'b0;
      cam_data = 8'h00;
      rst      = 1'b0;
    end
  endtask

  // Even bytes carry {k+1,0}, odd bytes {15-k,5}; k counts byte pairs in the frame.
  task automatic send_line(input int npix, input int rst_at);
    logic rst_prev;
    rst_prev = 1'b0;
    for (int b = 0; b < 2 * npix; b++) begin
      @(negedge pclk);
      if (rst_prev) begin
        chk("we_after_rst", {31'd0, we1}, 32'd0);
        chk("we0_after_rst", {31'd0, we0}, 32'd0);
        clear_writes();
      end
      cam_href = 1'b1;
      if (b % 2 == 0) begin
        cam_data = {4'(k + 1), 4'h0};
        e1_pix.push_back((k + 1) & 15);
        e1_cyc.push_back(cyc);
      end else begin
        cam_data = {4'(15 - k), 4'h5};
        e0_pix.push_back((15 - k) & 15);
        e0_cyc.push_back(cyc);
        k++;
      end
      rst = (b == rst_at);
      rst_prev = rst;
    end
    idle(3);
  endtask

  task automatic start_frame();
    @(negedge pclk);
    cam_vsync = 1'b0;
    clear_writes();
    e1_pix.delete(); e1_cyc.delete(); e0_pix.delete(); e0_cyc.delete();
    nd1 = 0; nd0 = 0; k = 0;
    idle(4);
  endtask

  task automatic end_frame();
    @(negedge pclk);
    cam_vsync = 1'b1;
    idle(5);
  endtask

  task automatic check_writes(input int n);
    chk("wr1_count", w1_addr.size(), n);
    chk("wr0_count", w0_addr.size(), n);
    for (int i = 0; i < n && i < w1_addr.size(); i++) begin
      chk($sformatf("wr1_addr[%0d]", i), w1_addr[i], i);
      chk($sformatf("wr1_pix[%0d]", i), w1_pix[i], e1_pix[i]);
      chk($sformatf("wr1_lat[%0d]", i), w1_cyc[i], e1_cyc[i] + 2);
    end
    for (int i = 0; i < n && i < w0_addr.size(); i++) begin
      chk($sformatf("wr0_addr[%0d]", i), w0_addr[i], i);
      chk($sformatf("wr0_pix[%0d]", i), w0_pix[i], e0_pix[i]);
      chk($sformatf("wr0_lat[%0d]", i), w0_cyc[i], e0_cyc[i] + 2);
    end
  endtask

  initial begin
    rst = 1'b1; capture_en = 1'b1; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
    nd1 = 0; nd0 = 0; k = 0;
    repeat (3) @(negedge pclk);
    chk("rst_we", {31'd0, we1}, 32'd0);
    chk("rst_addr", {13'd0, addr1}, 32'd0);
    chk("rst_pix", {28'd0, pix1}, 32'd0);
    chk("rst_done", {31'd0, done1}, 32'd0);
    chk("rst_lerr", {31'd0, lerr1}, 32'd0);
    chk("rst_ovf", {31'd0, ovf1}, 32'd0);
    chk("rst_fcnt", {24'd0, fcnt1}, 32'd0);
    rst = 1'b0;

    // partial frame after reset is discarded
    clear_writes();
    send_line(H, -1);
    send_line(H, -1);
    end_frame();
    chk("sync_wait_wr1", w1_addr.size(), 0);
    chk("sync_wait_wr0", w0_addr.size(), 0);
    chk("sync_wait_done", nd1, 0);

    // normal frame
    start_frame();
    repeat (V) send_line(H, -1);
    end_frame();
    check_writes(16);
    chk("a_done1", nd1, 1);
    chk("a_done0", nd0, 1);
    chk("a_fcnt1", {24'd0, fcnt1}, 32'd1);
    chk("a_fcnt0", {24'd0, fcnt0}, 32'd1);
    chk("a_lerr", {31'd0, lerr1}, 32'd0);
    chk("a_ovf", {31'd0, ovf1}, 32'd0);

    // short line
    start_frame();
    send_line(H, -1);
    chk("b_lerr_before", {31'd0, lerr1}, 32'd0);
    send_line(3, -1);
    chk("b_lerr1", {31'd0, lerr1}, 32'd1);
    chk("b_lerr0", {31'd0, lerr0}, 32'd1);
    send_line(H, -1);
    send_line(H, -1);
    end_frame();
    check_writes(15);
    chk("b_fcnt", {24'd0, fcnt1}, 32'd2);
    idle(4);
    chk("b_lerr_vblank", {31'd0, lerr1}, 32'd1);

    // five lines: overflow
    start_frame();
    chk("c_lerr_cleared", {31'd0, lerr1}, 32'd0);
    chk("c_ovf_clear", {31'd0, ovf1}, 32'd0);
    repeat (V) send_line(H, -1);
    check_writes(16);
    send_line(H, -1);
    chk("c_ovf1", {31'd0, ovf1}, 32'd1);
    chk("c_ovf0", {31'd0, ovf0}, 32'd1);
    chk("c_addr_hold", {13'd0, addr1}, 32'd15);
    chk("c_wr1_count", w1_addr.size(), 16);
    chk("c_lerr_mid", {31'd0, lerr1}, 32'd0);
    end_frame();
    chk("c_lerr_end", {31'd0, lerr1}, 32'd1);
    chk("c_ovf_vblank", {31'd0, ovf1}, 32'd1);
    chk("c_fcnt", {24'd0, fcnt1}, 32'd3);

    // capture_en dropped mid-frame
    start_frame();
    send_line(H, -1);
    send_line(H, -1);
    capture_en = 1'b0;
    send_line(H, -1);
    send_line(H, -1);
    end_frame();
    check_writes(16);
    chk("d_done", nd1, 1);
    chk("d_fcnt", {24'd0, fcnt1}, 32'd4);
    start_frame();
    repeat (V) send_line(H, -1);
    end_frame();
    chk("d_park_wr1", w1_addr.size(), 0);
    chk("d_park_wr0", w0_addr.size(), 0);
    chk("d_park_done", nd1, 0);
    chk("d_park_fcnt", {24'd0, fcnt1}, 32'd4);
    capture_en = 1'b1;
    end_frame();

    // reset mid-line
    start_frame();
    send_line(H, -1);
    send_line(H, 3);
    chk("e_fcnt_rst", {24'd0, fcnt1}, 32'd0);
    send_line(H, -1);
    send_line(H, -1);
    end_frame();
    chk("e_ignored_wr1", w1_addr.size(), 0);
    chk("e_ignored_done", nd1, 0);
    start_frame();
    repeat (V) send_line(H, -1);
    end_frame();
    check_writes(16);
    chk("e_done", nd1, 1);
    chk("e_fcnt", {24'd0, fcnt1}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ov7670_capture.md
Name: ov7670_capture

Overview:
- Camera-side capture stage directly upstream of the frame buffer that the VGA scan-out reads.
- Samples the OV7670 parallel bus (YUV422, one byte per pclk) and keeps only the luminance bytes.
- Writes one 4-bit grayscale pixel per camera pixel into the frame buffer, with a linear 19-bit address 0..H_PIXELS*V_LINES-1 that matches the scan-out addressing.
- Flags frame boundaries and malformed frames.

Parameters:
- H_PIXELS, 640, pixels per active line (2*H_PIXELS bytes while href high).
- V_LINES, 480, active lines per frame.
- Y_FIRST, 1, 1: byte order Y,U,Y,V (Y on even byte phase); 0: U,Y,V,Y (Y on odd byte phase).
- VSYNC_ACTIVE, 1'b1, level of cam_vsync during vertical blanking.

Ports:
- pclk  input  1  camera pixel clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- capture_en  input  1  arm capture of the next frame.
- cam_vsync  input  1  camera vertical sync.
- cam_href  input  1  camera line-valid.
- cam_data  input  8  camera data byte.
- frame_we  output  1  frame-buffer write strobe.
- frame_addr  output  19  frame-buffer write address.
- frame_pixel  output  4  frame-buffer write data (Y[7:4]).
- frame_done  output  1  one-cycle pulse at the end of a captured frame.
- line_err  output  1  sticky: a line in the current frame had a wrong pixel count.
- overflow  output  1  sticky: writes were attempted past the last address in the current frame.
- frame_cnt  output  8  count of completed frames, wraps 255->0.

Behaviour:
- **Clock and reset:** single clock pclk; reset is synchronous and active-high (rst), sampled on the rising edge of pclk.
- **Reset values:** all outputs 0; state = SYNC_WAIT; byte phase = 0; internal pixel and line counters = 0.
- **Input stage:** cam_vsync, cam_href and cam_data are registered once (stage r). All decisions use the registered values. Edges are detected against a second registered copy of vsync and href.
- **vs_blank:** defined as (vsync_r == VSYNC_ACTIVE).
- **State SYNC_WAIT:** discards the partial frame seen after reset. Moves to VBLANK on the first vs_blank rising edge.
- **State VBLANK:**
  - On the vs_blank falling edge with capture_en=1, move to ACTIVE and clear frame_addr, byte phase, pixel counter, line counter, line_err and overflow.
  - With capture_en=0, stay in VBLANK.
- **State ACTIVE, while href_r=1:**
  - Byte phase toggles every cycle.
  - A Y byte is a cycle with phase == (Y_FIRST ? 0 : 1).
  - The cycle after a Y byte is in stage r: frame_we=1, frame_pixel=Y[7:4], frame_addr = current address. The address then increments.
  - Total latency from the byte at the pins to the frame_we cycle: 2 pclk.
- **State ACTIVE, on href_r falling edge:**
  - Byte phase resets to 0.
  - If the line's pixel count != H_PIXELS, set line_err.
  - The pixel counter clears and the line counter increments.
- **Address saturation:**
  - When frame_addr == H_PIXELS*V_LINES-1 and a write has been issued, further Y bytes produce no frame_we and set overflow.
  - frame_addr holds at the last address and never wraps mid-frame.
- **Frame end (vs_blank rising edge in ACTIVE):**
  - frame_done=1 for exactly one cycle and frame_cnt increments.
  - If the line count != V_LINES, set line_err.
  - Return to VBLANK.
  - If href_r is still high when this happens, the partial line is counted and checked first. A write pending in the same cycle still completes.
- **capture_en behaviour:** deasserting capture_en during ACTIVE does not abort the frame. The frame completes, then capture parks in VBLANK.
- **frame_we outside ACTIVE:** frame_we is never asserted outside ACTIVE, including during href pulses in SYNC_WAIT and VBLANK.
- **Sticky flags:** line_err and overflow hold their value through VBLANK. They clear only at the next frame start or on rst.
- **Reset mid-frame:** rst during ACTIVE returns to SYNC_WAIT next cycle with frame_we=0. The remainder of that frame is ignored.

Test Plan:
- Reset, then one frame of 4 lines x 4 pixels (H_PIXELS=4, V_LINES=4, Y_FIRST=1), Y bytes 0x10,0x20,…: SYNC_WAIT skips the first frame. The second frame produces 16 writes at addresses 0..15 with pixels 1,2,…, one frame_done pulse, frame_cnt=1, line_err=0.
- Same frame with Y_FIRST=0: only odd-phase bytes are written. Each write occurs exactly 2 pclk after its byte is driven.
- One line with 3 pixels: line_err=1 after that href falls. It stays 1 through VBLANK and clears at the next frame start.
- Frame with 5 lines: the 17th Y byte gives no write, overflow=1, frame_addr holds at 15, and line_err is set at frame end.
- capture_en dropped mid-frame: the frame completes with 16 writes and frame_done. The next frame produces no writes and no frame_done.
- rst asserted for one cycle in mid-line: frame_we=0 the next cycle, and capture resumes only after a full vsync cycle.
